// File: rtl/csr_unit.sv
// csr_unit: privileged CSR file (CRMD..EENTRY, SAVEn, TID) with exception/ERTN side effects.
// The countdown timer (TCFG/TVAL/TICLR and ESTAT.TI) exists only when CSR_TIMER_EN is defined.
module csr_unit #(
   parameter int SAVE_NUM = 4,
   parameter int TIMER_W  = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [13:0] csr_num,
   output logic [31:0] csr_rdata,
   input  logic        csr_we,
   input  logic [31:0] csr_wmask,
   input  logic [31:0] csr_wdata,
   input  logic        excp_flush,
   input  logic        ertn_flush,
   input  logic [5:0]  ecode,
   input  logic [8:0]  esubcode,
   input  logic [31:0] epc,
   input  logic        badv_we,
   input  logic [31:0] badv,
   input  logic [7:0]  hw_int,
   input  logic        ipi_int,
   output logic [31:0] era,
   output logic [31:0] eentry,
   output logic        has_int
);

   localparam logic [13:0] A_CRMD   = 14'h000;
   localparam logic [13:0] A_PRMD   = 14'h001;
   localparam logic [13:0] A_ECFG   = 14'h004;
   localparam logic [13:0] A_ESTAT  = 14'h005;
   localparam logic [13:0] A_ERA    = 14'h006;
   localparam logic [13:0] A_BADV   = 14'h007;
   localparam logic [13:0] A_EENTRY = 14'h00C;
   localparam logic [13:0] A_SAVE0  = 14'h030;
   localparam logic [13:0] A_TID    = 14'h040;
   localparam logic [12:0] LIE_MASK = 13'h1BFF;

   if (SAVE_NUM < 1 || SAVE_NUM > 16 || TIMER_W < 8 || TIMER_W > 32) begin : g_param_check
      $error("csr_unit: SAVE_NUM or TIMER_W out of range");
   end

   logic [31:0] wset, wkeep;
   logic        wr_crmd, wr_prmd, wr_ecfg, wr_estat, wr_era, wr_badv, wr_eentry, wr_tid;

   logic [8:0]  crmd_q,   crmd_d;
   logic [2:0]  prmd_q,   prmd_d;
   logic [12:0] ecfg_q,   ecfg_d;
   logic [1:0]  is_sw_q,  is_sw_d;
   logic [7:0]  is_hw_q,  is_hw_d;
   logic        is_ipi_q, is_ipi_d;
   logic [5:0]  ecode_q,  ecode_d;
   logic [8:0]  esub_q,   esub_d;
   logic [31:0] era_q,    era_d;
   logic [31:0] badv_q,   badv_d;
   logic [25:0] eentry_q, eentry_d;
   logic [31:0] tid_q,    tid_d;
   logic        timer_irq;
   logic [12:0] is_bits;
   logic [SAVE_NUM-1:0][31:0] save_rd;

   // Masked write: bits set in wmask take wdata, the rest keep their old value.
   assign wset  = csr_wmask & csr_wdata;
   assign wkeep = ~csr_wmask;

   assign wr_crmd   = csr_we && (csr_num == A_CRMD);
   assign wr_prmd   = csr_we && (csr_num == A_PRMD);
   assign wr_ecfg   = csr_we && (csr_num == A_ECFG);
   assign wr_estat  = csr_we && (csr_num == A_ESTAT);
   assign wr_era    = csr_we && (csr_num == A_ERA);
   assign wr_badv   = csr_we && (csr_num == A_BADV);
   assign wr_eentry = csr_we && (csr_num == A_EENTRY);
   assign wr_tid    = csr_we && (csr_num == A_TID);

   always_comb begin
      crmd_d   = crmd_q;
      prmd_d   = prmd_q;
      ecfg_d   = ecfg_q;
      is_sw_d  = is_sw_q;
      is_hw_d  = hw_int;
      is_ipi_d = ipi_int;
      ecode_d  = ecode_q;
      esub_d   = esub_q;
      era_d    = era_q;
      badv_d   = badv_q;
      eentry_d = eentry_q;
      tid_d    = tid_q;

      // Registers touched by a flush ignore a same-cycle software write.
      if (excp_flush) begin
         crmd_d[2:0] = 3'b000;
      end else if (ertn_flush) begin
         crmd_d[2:0] = prmd_q;
      end else if (wr_crmd) begin
         crmd_d = wset[8:0] | (wkeep[8:0] & crmd_q);
      end

      if (excp_flush) begin
         prmd_d = crmd_q[2:0];
      end else if (wr_prmd) begin
         prmd_d = wset[2:0] | (wkeep[2:0] & prmd_q);
      end

      if (wr_ecfg) begin
         ecfg_d = (wset[12:0] | (wkeep[12:0] & ecfg_q)) & LIE_MASK;
      end

      if (excp_flush) begin
         ecode_d = ecode;
         esub_d  = esubcode;
      end else if (wr_estat) begin
         is_sw_d = wset[1:0] | (wkeep[1:0] & is_sw_q);
      end

      if (excp_flush) begin
         era_d = epc;
      end else if (wr_era) begin
         era_d = wset | (wkeep & era_q);
      end

      if (excp_flush) begin
         if (badv_we) begin
            badv_d = badv;
         end
      end else if (wr_badv) begin
         badv_d = wset | (wkeep & badv_q);
      end

      if (wr_eentry) begin
         eentry_d = wset[31:6] | (wkeep[31:6] & eentry_q);
      end

      if (wr_tid) begin
         tid_d = wset | (wkeep & tid_q);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         crmd_q   <= 9'h008;
         prmd_q   <= '0;
         ecfg_q   <= '0;
         is_sw_q  <= '0;
         is_hw_q  <= '0;
         is_ipi_q <= 1'b0;
         ecode_q  <= '0;
         esub_q   <= '0;
         era_q    <= '0;
         badv_q   <= '0;
         eentry_q <= '0;
         tid_q    <= '0;
      end else begin
         crmd_q   <= crmd_d;
         prmd_q   <= prmd_d;
         ecfg_q   <= ecfg_d;
         is_sw_q  <= is_sw_d;
         is_hw_q  <= is_hw_d;
         is_ipi_q <= is_ipi_d;
         ecode_q  <= ecode_d;
         esub_q   <= esub_d;
         era_q    <= era_d;
         badv_q   <= badv_d;
         eentry_q <= eentry_d;
         tid_q    <= tid_d;
      end
   end

   for (genvar gi = 0; gi < SAVE_NUM; gi++) begin : g_save
      logic [31:0] save_q, save_d;

      always_comb begin
         save_d = save_q;
         if (csr_we && (csr_num == A_SAVE0 + 14'(gi))) begin
            save_d = wset | (wkeep & save_q);
         end
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            save_q <= '0;
         end else begin
            save_q <= save_d;
         end
      end

      assign save_rd[gi] = save_q;
   end

`ifdef CSR_TIMER_EN
   localparam logic [13:0] A_TCFG  = 14'h041;
   localparam logic [13:0] A_TVAL  = 14'h042;
   localparam logic [13:0] A_TICLR = 14'h044;

   logic [TIMER_W-1:0] tcfg_q, tcfg_d;
   logic [TIMER_W-1:0] tval_q, tval_d;
   logic               ti_q, ti_d;
   logic               wr_tcfg, clr_ti;

   assign wr_tcfg = csr_we && (csr_num == A_TCFG);
   assign clr_ti  = csr_we && (csr_num == A_TICLR) && csr_wmask[0] && csr_wdata[0];

   always_comb begin
      tcfg_d = tcfg_q;
      tval_d = tval_q;
      ti_d   = ti_q;
      if (wr_tcfg) begin
         tcfg_d = wset[TIMER_W-1:0] | (wkeep[TIMER_W-1:0] & tcfg_q);
         tval_d = {tcfg_d[TIMER_W-1:2], 2'b00};
      end else if (tcfg_q[0]) begin
         if (tval_q != '0) begin
            tval_d = tval_q - TIMER_W'(1);
         end else if (tcfg_q[1]) begin
            tval_d = {tcfg_q[TIMER_W-1:2], 2'b00};
         end
      end
      if (clr_ti) begin
         ti_d = 1'b0;
      end
      // Expiry is checked last so it wins over a coincident clear.
      if (!wr_tcfg && tcfg_q[0] && (tval_q == TIMER_W'(1))) begin
         ti_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tcfg_q <= '0;
         tval_q <= '0;
         ti_q   <= 1'b0;
      end else begin
         tcfg_q <= tcfg_d;
         tval_q <= tval_d;
         ti_q   <= ti_d;
      end
   end

   assign timer_irq = ti_q;
`else
   assign timer_irq = 1'b0;
`endif

   assign is_bits = {is_ipi_q, timer_irq, 1'b0, is_hw_q, is_sw_q};
   assign has_int = crmd_q[2] & (|(is_bits & ecfg_q));
   assign era     = era_q;
   assign eentry  = {eentry_q, 6'b000000};

   always_comb begin
      csr_rdata = 32'h0;
      case (csr_num)
         A_CRMD:   csr_rdata = {23'h0, crmd_q};
         A_PRMD:   csr_rdata = {29'h0, prmd_q};
         A_ECFG:   csr_rdata = {19'h0, ecfg_q};
         A_ESTAT:  csr_rdata = {1'b0, esub_q, ecode_q, 3'b000, is_bits};
         A_ERA:    csr_rdata = era_q;
         A_BADV:   csr_rdata = badv_q;
         A_EENTRY: csr_rdata = {eentry_q, 6'b000000};
         A_TID:    csr_rdata = tid_q;
`ifdef CSR_TIMER_EN
         A_TCFG:   csr_rdata = 32'(tcfg_q);
         A_TVAL:   csr_rdata = 32'(tval_q);
`endif
         default:  csr_rdata = 32'h0;
      endcase
      if (csr_num[13:4] == 10'h003) begin
         for (int i = 0; i < SAVE_NUM; i++) begin
            if (csr_num[3:0] == 4'(i)) begin
               csr_rdata = save_rd[i];
            end
         end
      end
   end

endmodule

// File: tb/tb_csr_unit.sv
// Bench for csr_unit: register-image reference model checked every cycle, a vector table,
// directed exception/interrupt/timer sequences and a randomized phase.
module tb_csr_unit;

   localparam int SAVE_N = 2;
   localparam int TW     = 16;
`ifdef CSR_TIMER_EN
   localparam bit TIMER_ON = 1'b1;
`else
   localparam bit TIMER_ON = 1'b0;
`endif
   localparam logic [31:0] TW_MASK = (32'h1 << TW) - 32'h1;

   logic        clk = 1'b0;
   logic        rst;
   logic [13:0] num;
   logic [31:0] rdata;
   logic        we;
   logic [31:0] wmask, wdata;
   logic        excp, ertn;
   logic [5:0]  ecode_i;
   logic [8:0]  esub_i;
   logic [31:0] epc_i;
   logic        badv_we_i;
   logic [31:0] badv_i;
   logic [7:0]  hw;
   logic        ipi;
   logic [31:0] era_o, eentry_o;
   logic        has_int_o;

   int total = 0;
   int bad   = 0;

   csr_unit #(.SAVE_NUM(SAVE_N), .TIMER_W(TW)) dut (
      .clk(clk), .reset(rst), .csr_num(num), .csr_rdata(rdata),
      .csr_we(we), .csr_wmask(wmask), .csr_wdata(wdata),
      .excp_flush(excp), .ertn_flush(ertn), .ecode(ecode_i), .esubcode(esub_i),
      .epc(epc_i), .badv_we(badv_we_i), .badv(badv_i),
      .hw_int(hw), .ipi_int(ipi), .era(era_o), .eentry(eentry_o), .has_int(has_int_o)
   );

   always #5 clk = ~clk;

   // Reference model: architectural image of every address below 0x80.
   bit [31:0] img [0:127];

   function automatic bit [31:0] wmask_of(int a);
      if (a >= 'h30 && a < 'h30 + SAVE_N) return 32'hFFFFFFFF;
      case (a)
         'h00: return 32'h000001FF;
         'h01: return 32'h00000007;
         'h04: return 32'h00001BFF;
         'h05: return 32'h00000003;
         'h06, 'h07, 'h40: return 32'hFFFFFFFF;
         'h0C: return 32'hFFFFFFC0;
         'h41: return TIMER_ON ? TW_MASK : 32'h0;
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 128; i++) img[i] = 32'h0;
      img[0] = 32'h8;
   endtask

   function automatic bit [31:0] model_read(int a);
      return (a < 128) ? img[a] : 32'h0;
   endfunction

   task automatic model_step();
      bit [31:0] n [0:127];
      bit [31:0] eff;
      bit        blocked, fire;
      int        a;
      a = int'(num);
      if (rst) begin
         model_reset();
         return;
      end
      n = img;
      fire = 1'b0;
      if (excp) begin
         n[1] = img[0] & 32'h7;
         n[0] = img[0] & ~32'h7;
         n[5][21:16] = ecode_i;
         n[5][30:22] = esub_i;
         n[6] = epc_i;
         if (badv_we_i) n[7] = badv_i;
      end else if (ertn) begin
         n[0] = (img[0] & ~32'h7) | (img[1] & 32'h7);
      end
      blocked = excp ? (a inside {0, 1, 5, 6, 7}) : (ertn && a == 0);
      if (we && a < 128 && !blocked) begin
         eff  = wmask & wmask_of(a);
         n[a] = (img[a] & ~eff) | (wdata & eff);
      end
      n[5][9:2] = hw;
      n[5][12]  = ipi;
      if (TIMER_ON) begin
         if (we && a == 'h41) begin
            n['h42] = n['h41] & TW_MASK & ~32'h3;
         end else if (img['h41][0]) begin
            if (img['h42] != 0) begin
               n['h42] = img['h42] - 1;
               fire = (img['h42] == 1);
            end else if (img['h41][1]) begin
               n['h42] = img['h41] & ~32'h3;
            end
         end
         if (we && a == 'h44 && wmask[0] && wdata[0]) n[5][11] = 1'b0;
         if (fire) n[5][11] = 1'b1;
      end
      img = n;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // One clock: compare combinational outputs with the model, then advance both.
   task automatic cycle();
      bit [31:0] e5, e4;
      #1;
      e5 = img[5];
      e4 = img[4];
      chk("rdata", rdata, model_read(int'(num)));
      chk("has_int", {31'h0, has_int_o}, {31'h0, img[0][2] & (|(e5[12:0] & e4[12:0]))});
      chk("era", era_o, img[6]);
      chk("eentry", eentry_o, img['h0C]);
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rst = 1'b0; we = 1'b0; wmask = 32'h0; wdata = 32'h0;
      excp = 1'b0; ertn = 1'b0; ecode_i = '0; esub_i = '0; epc_i = '0;
      badv_we_i = 1'b0; badv_i = '0; hw = '0; ipi = 1'b0; num = '0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      model_reset();
      rst = 1'b0;
   endtask

   task automatic wr(input logic [13:0] a, input logic [31:0] m, input logic [31:0] d);
      num = a; we = 1'b1; wmask = m; wdata = d;
      cycle();
      we = 1'b0;
   endtask

   task automatic read_chk(input string name, input logic [13:0] a, input logic [31:0] exp);
      we = 1'b0;
      num = a;
      #1;
      chk(name, rdata, exp);
      $display("read %s addr=0x%03h data=0x%08h", name, a, rdata);
   endtask

   task automatic ti_chk(input string name, input logic exp);
      we = 1'b0;
      num = 14'h005;
      #1;
      chk(name, {31'h0, rdata[11]}, {31'h0, exp});
   endtask

   typedef struct {
      string       name;
      logic [13:0] num;
      logic [31:0] mask;
      logic [31:0] data;
      logic [31:0] exp;
   } vec_t;

   vec_t vt [19];
   logic [13:0] addrs [18];

   initial begin
      vt[0]  = '{"crmd_all",   14'h000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h000001FF};
      vt[1]  = '{"prmd_all",   14'h001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000007};
      vt[2]  = '{"ecfg_all",   14'h004, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00001BFF};
      vt[3]  = '{"estat_sw",   14'h005, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000003};
      vt[4]  = '{"era",        14'h006, 32'hFFFFFFFF, 32'h12345678, 32'h12345678};
      vt[5]  = '{"badv_mask",  14'h007, 32'h0000FFFF, 32'h89ABCDEF, 32'h0000CDEF};
      vt[6]  = '{"eentry",     14'h00C, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFC0};
      vt[7]  = '{"save0",      14'h030, 32'hFFFFFFFF, 32'hA5A5A5A5, 32'hA5A5A5A5};
      vt[8]  = '{"save1_mask", 14'h031, 32'hFFFF0000, 32'hFFFFFFFF, 32'hFFFF0000};
      vt[9]  = '{"save2_none", 14'h032, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
      vt[10] = '{"tid",        14'h040, 32'hFFFFFFFF, 32'hDEADBEEF, 32'hDEADBEEF};
      vt[11] = '{"alias_1030", 14'h1030, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
      vt[12] = '{"save0_keep", 14'h030, 32'h00000000, 32'hFFFFFFFF, 32'hA5A5A5A5};
      vt[13] = '{"tcfg",       14'h041, 32'hFFFFFFFF, 32'hFFFFFFF0, TIMER_ON ? 32'h0000FFF0 : 32'h0};
      vt[14] = '{"tval_ro",    14'h042, 32'hFFFFFFFF, 32'h00001234, TIMER_ON ? 32'h0000FFF0 : 32'h0};
      vt[15] = '{"ticlr_rd0",  14'h044, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
      vt[16] = '{"crmd_ie_off", 14'h000, 32'h00000004, 32'h00000000, 32'h000001FB};
      vt[17] = '{"save_last",  14'h03F, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
      vt[18] = '{"ecfg_bit10", 14'h004, 32'h00000400, 32'hFFFFFFFF, 32'h00001BFF};
      addrs = '{14'h000, 14'h001, 14'h004, 14'h005, 14'h006, 14'h007, 14'h00C, 14'h030,
                14'h031, 14'h032, 14'h03F, 14'h040, 14'h041, 14'h042, 14'h044, 14'h002,
                14'h043, 14'h041};

      // Reset state.
      do_reset();
      for (int i = 0; i < 15; i++) begin
         read_chk("reset_val", addrs[i], (addrs[i] == 14'h000) ? 32'h8 : 32'h0);
      end
      chk("reset_has_int", {31'h0, has_int_o}, 32'h0);

      // Vector table.
      for (int i = 0; i < 19; i++) begin
         wr(vt[i].num, vt[i].mask, vt[i].data);
         read_chk(vt[i].name, vt[i].num, vt[i].exp);
      end

      // Exception entry and return.
      do_reset();
      wr(14'h000, 32'hFFFFFFFF, 32'h7);
      excp = 1'b1; ecode_i = 6'h0B; esub_i = 9'h0; epc_i = 32'h1C000100; num = 14'h000;
      cycle();
      excp = 1'b0;
      read_chk("excp_crmd", 14'h000, 32'h0);
      read_chk("excp_prmd", 14'h001, 32'h7);
      num = 14'h005;
      #1;
      chk("excp_ecode", {26'h0, rdata[21:16]}, 32'h0B);
      chk("excp_era", era_o, 32'h1C000100);
      ertn = 1'b1;
      cycle();
      ertn = 1'b0;
      read_chk("ertn_crmd", 14'h000, 32'h7);

      // Interrupt pending path.
      do_reset();
      wr(14'h004, 32'hFFFFFFFF, 32'h4);
      wr(14'h000, 32'hFFFFFFFF, 32'h4);
      hw = 8'h01;
      #1;
      chk("int_not_yet", {31'h0, has_int_o}, 32'h0);
      cycle();
      chk("int_sampled", {31'h0, has_int_o}, 32'h1);
      wr(14'h000, 32'hFFFFFFFF, 32'h0);
      chk("int_ie_off", {31'h0, has_int_o}, 32'h0);
      hw = 8'h00;

`ifdef CSR_TIMER_EN
      // One-shot countdown.
      do_reset();
      wr(14'h041, 32'hFFFFFFFF, 32'hD);
      read_chk("oneshot_load", 14'h042, 32'd12);
      for (int k = 0; k < 11; k++) cycle();
      read_chk("oneshot_at1", 14'h042, 32'd1);
      ti_chk("oneshot_ti0", 1'b0);
      cycle();
      read_chk("oneshot_at0", 14'h042, 32'd0);
      ti_chk("oneshot_ti1", 1'b1);
      for (int k = 0; k < 3; k++) cycle();
      read_chk("oneshot_hold", 14'h042, 32'd0);
      wr(14'h044, 32'hFFFFFFFF, 32'h1);
      ti_chk("ticlr", 1'b0);

      // Periodic with coincident clear.
      do_reset();
      wr(14'h041, 32'hFFFFFFFF, 32'hB);
      for (int k = 0; k < 7; k++) cycle();
      ti_chk("per_ti_before", 1'b0);
      cycle();
      ti_chk("per_ti_first", 1'b1);
      wr(14'h044, 32'hFFFFFFFF, 32'h1);
      read_chk("per_reload", 14'h042, 32'd8);
      ti_chk("per_cleared", 1'b0);
      for (int k = 0; k < 7; k++) cycle();
      ti_chk("per_ti_pre2", 1'b0);
      wr(14'h044, 32'hFFFFFFFF, 32'h1);
      ti_chk("per_set_wins", 1'b1);

      // Reset in the middle of a countdown.
      wr(14'h041, 32'hFFFFFFFF, 32'hD);
      for (int k = 0; k < 5; k++) cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      read_chk("rst_mid_tval", 14'h042, 32'd0);
      ti_chk("rst_mid_ti", 1'b0);
`else
      // Timer absent: writes to its addresses have no effect.
      do_reset();
      wr(14'h041, 32'hFFFFFFFF, 32'hD);
      for (int k = 0; k < 20; k++) cycle();
      read_chk("notimer_tval", 14'h042, 32'd0);
      read_chk("notimer_tcfg", 14'h041, 32'd0);
      ti_chk("notimer_ti", 1'b0);
`endif

      // Randomized traffic against the model.
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         rst   = ($urandom_range(0, 499) == 0);
         we    = 1'($urandom_range(0, 1));
         num   = ($urandom_range(0, 15) == 0) ? 14'($urandom) : addrs[$urandom_range(0, 17)];
         wmask = ($urandom_range(0, 3) == 0) ? $urandom : 32'hFFFFFFFF;
         wdata = $urandom;
         if (num == 14'h041 && $urandom_range(0, 3) != 0) wdata = $urandom_range(0, 95);
         excp  = ($urandom_range(0, 29) == 0);
         ertn  = !excp && ($urandom_range(0, 29) == 0);
         ecode_i   = 6'($urandom);
         esub_i    = 9'($urandom);
         epc_i     = $urandom;
         badv_we_i = 1'($urandom_range(0, 1));
         badv_i    = $urandom;
         if ($urandom_range(0, 7) == 0) hw = 8'($urandom);
         if ($urandom_range(0, 7) == 0) ipi = 1'($urandom_range(0, 1));
         cycle();
      end
      idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
